mcht_enc: RTL and testbench



---
 rtl/mcht_enc.sv | 152 +++++++++++++++
 tb/tb_mcht_enc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mcht_enc.sv
// Manchester line encoder: takes a parallel message over a REQ/ACK handshake and
// serialises it as start symbol + data LSB first + high idle guard on a registered TXD.
module mcht_enc #(
  parameter int unsigned pMSG_LEN  = 8,
  parameter int unsigned pHALF_CYC = 4,
  parameter int unsigned pIDLE_CYC = 16
) (
  input  logic                CLK100M,
  input  logic                RST_N,
  input  logic [pMSG_LEN-1:0] MSG_IN,
  input  logic                MSG_REQ,
  output logic                MSG_ACK,
  output logic                BUSY,
  output logic                TXD
);

  localparam int unsigned HW = (pHALF_CYC > 1) ? $clog2(pHALF_CYC) : 1;
  localparam int unsigned IW = (pMSG_LEN > 1) ? $clog2(pMSG_LEN) : 1;
  localparam int unsigned GW = (pIDLE_CYC > 1) ? $clog2(pIDLE_CYC) : 1;

  localparam logic [HW-1:0] HALF_LAST  = HW'(pHALF_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(pMSG_LEN - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(pIDLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START_L = 3'd1,
    S_START_H = 3'd2,
    S_BIT_H1  = 3'd3,
    S_BIT_H2  = 3'd4,
    S_GUARD   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         half_q, half_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [GW-1:0]         guard_q, guard_d;
  logic [pMSG_LEN-1:0]   shift_q, shift_d;
  logic                  txd_d, ack_d, busy_d;
  logic                  accept;
  logic                  half_last;

  // State and registered outputs; reset drops any frame and forces the line high
  always_ff @(posedge CLK100M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_GUARD;
      half_q  <= '0;
      idx_q   <= '0;
      guard_q <= '0;
      shift_q <= '0;
      TXD     <= 1'b1;
      MSG_ACK <= 1'b0;
      BUSY    <= 1'b1;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      idx_q   <= idx_d;
      guard_q <= guard_d;
      shift_q <= shift_d;
      TXD     <= txd_d;
      MSG_ACK <= ack_d;
      BUSY    <= busy_d;
    end
  end

  // Next-state logic; TXD/BUSY are decoded from the next state so they land with it
  always_comb begin
    state_d   = state_q;
    half_d    = half_q + HW'(1);
    idx_d     = idx_q;
    guard_d   = guard_q;
    shift_d   = shift_q;
    ack_d     = 1'b0;
    accept    = 1'b0;
    txd_d     = 1'b1;
    busy_d    = 1'b1;
    half_last = (half_q == HALF_LAST);

    case (state_q)
      S_IDLE: begin
        half_d = '0;
        accept = MSG_REQ;
      end
      S_START_L: begin
        if (half_last) begin
          state_d = S_START_H;
          half_d  = '0;
        end
      end
      S_START_H: begin
        if (half_last) begin
          state_d = S_BIT_H1;
          half_d  = '0;
          idx_d   = '0;
        end
      end
      S_BIT_H1: begin
        if (half_last) begin
          state_d = S_BIT_H2;
          half_d  = '0;
        end
      end
      S_BIT_H2: begin
        if (half_last) begin
          half_d = '0;
          if (idx_q != IDX_LAST) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IW'(1);
            state_d = S_BIT_H1;
          end else begin
            state_d = S_GUARD;
            guard_d = '0;
          end
        end
      end
      S_GUARD: begin
        half_d = '0;
        if (guard_q == GUARD_LAST) begin
          guard_d = '0;
          // The closing guard edge doubles as the first idle edge, so a held
          // request restarts with no extra high gap beyond the guard.
          if (MSG_REQ) accept = 1'b1;
          else         state_d = S_IDLE;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: begin
        state_d = S_GUARD;
        half_d  = '0;
        guard_d = '0;
      end
    endcase

    if (accept) begin
      shift_d = MSG_IN;
      state_d = S_START_L;
      half_d  = '0;
      ack_d   = 1'b1;
    end

    case (state_d)
      S_IDLE:    begin txd_d = 1'b1;        busy_d = 1'b0; end
      S_START_L: txd_d = 1'b0;
      S_START_H: txd_d = 1'b1;
      S_BIT_H1:  txd_d = ~shift_d[0];
      S_BIT_H2:  txd_d = shift_d[0];
      default:   txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mcht_enc.sv
// Directed bench for mcht_enc: reset guard, frame waveforms, held/pending requests,
// mid-frame reset and a back-to-back sweep of all byte values.
module tb_mcht_enc;

  logic       CLK100M;
  logic       RST_N;
  logic [7:0] MSG_IN;
  logic       MSG_REQ;
  logic       MSG_ACK;
  logic       BUSY;
  logic       TXD;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_cnt = 0;

  mcht_enc #(.pMSG_LEN(8), .pHALF_CYC(4), .pIDLE_CYC(16)) dut (
    .CLK100M (CLK100M),
    .RST_N   (RST_N),
    .MSG_IN  (MSG_IN),
    .MSG_REQ (MSG_REQ),
    .MSG_ACK (MSG_ACK),
    .BUSY    (BUSY),
    .TXD     (TXD)
  );

  initial CLK100M = 1'b0;
  always #5 CLK100M = ~CLK100M;

  always @(posedge CLK100M) cyc <= cyc + 1;
  always @(negedge CLK100M) if (MSG_ACK === 1'b1) ack_cnt <= ack_cnt + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100M);
    #1;
  endtask

  // Returns the edge count of the ACK edge, or -1 on timeout
  task automatic wait_ack(output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (MSG_ACK === 1'b1) begin
        c = cyc;
        break;
      end
    end
  endtask

  // Called on the sample just after the accept edge; records 88 cycles of TXD
  task automatic capture(output logic [87:0] v, output logic ok);
    ok = 1'b1;
    for (int k = 0; k < 88; k++) begin
      if (k != 0) tick();
      v[k] = TXD;
      if (BUSY !== 1'b1) ok = 1'b0;
      if (MSG_ACK !== ((k == 0) ? 1'b1 : 1'b0)) ok = 1'b0;
    end
  endtask

  function automatic logic [87:0] exp_frame(input logic [7:0] b);
    logic [87:0] v;
    int i, h;
    for (int k = 0; k < 88; k++) begin
      if (k < 4)       v[k] = 1'b0;
      else if (k < 8)  v[k] = 1'b1;
      else if (k < 72) begin
        i = (k - 8) / 8;
        h = (k - 8) % 8;
        v[k] = (h < 4) ? ~b[i] : b[i];
      end else         v[k] = 1'b1;
    end
    return v;
  endfunction

  initial begin
    logic [87:0] fr;
    logic [17:0] halves;
    logic [17:0] a5_halves;
    logic        ok;
    logic        txd_ok;
    int          c0, c1, c2, a0, rel;

    a5_halves = 18'b100110010110011010;

    // Reset and power-up guard
    RST_N = 1'b0; MSG_REQ = 1'b0; MSG_IN = 8'h00;
    #23;
    chk("rst_txd", TXD, 1'b1);
    chk("rst_busy", BUSY, 1'b1);
    chk("rst_ack", MSG_ACK, 1'b0);
    RST_N = 1'b1;
    txd_ok = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (TXD !== 1'b1) txd_ok = 1'b0;
    end
    chk("guard_busy_hi", BUSY, 1'b1);
    tick();
    if (TXD !== 1'b1) txd_ok = 1'b0;
    chk("guard_busy_lo", BUSY, 1'b0);
    chk("guard_txd_high", txd_ok, 1'b1);
    chk("guard_no_ack", ack_cnt, 0);
    repeat (3) tick();

    // Single A5 frame
    MSG_IN = 8'hA5; MSG_REQ = 1'b1;
    wait_ack(c0);
    MSG_REQ = 1'b0;
    chk("a5_ack_seen", (c0 > 0), 1'b1);
    capture(fr, ok);
    chk("a5_flags", ok, 1'b1);
    chk("a5_frame", fr, exp_frame(8'hA5));
    for (int j = 0; j < 18; j++) halves[j] = fr[4*j+1];
    chk("a5_halves", halves, a5_halves);
    tick();
    chk("a5_busy_fall", BUSY, 1'b0);
    chk("a5_txd_idle", TXD, 1'b1);
    chk("a5_one_ack", ack_cnt, 1);
    repeat (2) tick();

    // Held request: 3C then C3 back to back
    MSG_IN = 8'h3C; MSG_REQ = 1'b1;
    wait_ack(c1);
    MSG_IN = 8'hC3;
    capture(fr, ok);
    chk("held1_flags", ok, 1'b1);
    chk("held1_frame", fr, exp_frame(8'h3C));
    wait_ack(c2);
    MSG_REQ = 1'b0;
    chk("held_spacing", c2 - c1, 88);
    capture(fr, ok);
    chk("held2_flags", ok, 1'b1);
    chk("held2_frame", fr, exp_frame(8'hC3));

    // Request raised mid-frame stays pending until the frame ends
    MSG_IN = 8'h5A; MSG_REQ = 1'b1;
    wait_ack(c0);
    MSG_REQ = 1'b0;
    repeat (20) tick();
    MSG_IN = 8'hFF; MSG_REQ = 1'b1;
    a0 = ack_cnt;
    repeat (67) tick();
    chk("pend_no_ack", ack_cnt, a0);
    MSG_IN = 8'h81;
    wait_ack(c1);
    MSG_REQ = 1'b0;
    MSG_IN = 8'h00;
    chk("pend_spacing", c1 - c0, 88);
    capture(fr, ok);
    chk("pend_flags", ok, 1'b1);
    chk("pend_frame", fr, exp_frame(8'h81));

    // Asynchronous reset in the middle of a frame
    MSG_IN = 8'h00; MSG_REQ = 1'b1;
    wait_ack(c0);
    MSG_REQ = 1'b0;
    repeat (30) tick();
    chk("mid_txd_low", TXD, 1'b0);
    #1 RST_N = 1'b0;
    #1;
    chk("mid_rst_txd", TXD, 1'b1);
    chk("mid_rst_busy", BUSY, 1'b1);
    chk("mid_rst_ack", MSG_ACK, 1'b0);
    MSG_IN = 8'h6B; MSG_REQ = 1'b1;
    repeat (2) @(posedge CLK100M);
    #3 RST_N = 1'b1;
    rel = cyc;
    wait_ack(c1);
    MSG_REQ = 1'b0;
    chk("mid_guard_wait", c1 - rel, 16);
    capture(fr, ok);
    chk("mid_flags", ok, 1'b1);
    chk("mid_frame", fr, exp_frame(8'h6B));

    // Back-to-back sweep of every byte value
    a0 = ack_cnt;
    for (int b = 0; b < 256; b++) begin
      MSG_IN = 8'(b); MSG_REQ = 1'b1;
      wait_ack(c0);
      MSG_REQ = 1'b0;
      capture(fr, ok);
      chk($sformatf("sweep_%02h", b), {ok, fr}, {1'b1, exp_frame(8'(b))});
    end
    tick();
    chk("sweep_acks", ack_cnt - a0, 256);
    chk("sweep_idle", BUSY, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
